// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, constants and the pipeline bubble value used by exe_mem and mem_wb.
package mem_wb_pkg;
    localparam int ADDR_WIDTH     = 32;
    localparam int RDATA_WIDTH    = 32;
    localparam int RADDR_WIDTH    = 5;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [RDATA_WIDTH-1:0]    ZERO          = '0;
    localparam logic [RADDR_WIDTH-1:0]    ZERO_REG      = '0;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ZERO_ADDR = '0;
    localparam logic                      WRITE_DISABLE = 1'b0;

    typedef struct packed {
        logic                      valid;
        logic [ADDR_WIDTH-1:0]     inst_address;
        logic [RDATA_WIDTH-1:0]    reg_wdata;
        logic [RADDR_WIDTH-1:0]    reg_waddr;
        logic                      reg_we;
        logic                      csr_we;
        logic [RDATA_WIDTH-1:0]    csr_wdata;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    } wb_regs_t;

    localparam wb_regs_t BUBBLE = '{
        valid:        1'b0,
        inst_address: ZERO,
        reg_wdata:    ZERO,
        reg_waddr:    ZERO_REG,
        reg_we:       WRITE_DISABLE,
        csr_we:       WRITE_DISABLE,
        csr_wdata:    ZERO,
        csr_waddr:    CSR_ZERO_ADDR
    };
endpackage

// File: rtl/mem_wb_retire_counter.sv
// retire_counter: wrapping retired-instruction counter, sync active-low reset.
module retire_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] cnt_out
);
    always_ff @(posedge clk_in)
        if (!reset_in) cnt_out <= '0;
        else if (inc_in) cnt_out <= cnt_out + WIDTH'(1);
endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with flush/hold/bubble control.
// Optional retired-instruction counter enabled by MEM_WB_RETIRE_CNT_EN.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int RETIRE_CNT_WIDTH = 64
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        valid_in,
    input  logic [ADDR_WIDTH-1:0]       inst_address_in,
    input  logic [RDATA_WIDTH-1:0]      reg_wdata_in,
    input  logic [RADDR_WIDTH-1:0]      reg_waddr_in,
    input  logic                        reg_we_in,
    input  logic                        csr_we_in,
    input  logic [RDATA_WIDTH-1:0]      csr_wdata_in,
    input  logic [CSR_ADDR_WIDTH-1:0]   csr_waddr_in,
    input  logic                        mem_stall_in,
    input  logic                        wb_stall_in,
    input  logic                        flush_in,
    output logic                        valid_out,
    output logic [ADDR_WIDTH-1:0]       inst_address_out,
    output logic [RDATA_WIDTH-1:0]      reg_wdata_out,
    output logic [RADDR_WIDTH-1:0]      reg_waddr_out,
    output logic                        reg_we_out,
    output logic                        csr_we_out,
    output logic [RDATA_WIDTH-1:0]      csr_wdata_out,
    output logic [CSR_ADDR_WIDTH-1:0]   csr_waddr_out
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_out
`endif
);
    wb_regs_t r;
    // Write enables of a bubble from the memory stage never reach the register
    wb_regs_t nxt;
    assign nxt = '{valid_in, inst_address_in, reg_wdata_in, reg_waddr_in, reg_we_in & valid_in,
                   csr_we_in & valid_in, csr_wdata_in, csr_waddr_in};

    always_ff @(posedge clk_in)
        if (!reset_in || flush_in) r <= BUBBLE;
        else if (!wb_stall_in) r <= mem_stall_in ? BUBBLE : nxt;

    assign valid_out        = r.valid;
    assign inst_address_out = r.inst_address;
    assign reg_wdata_out    = r.reg_wdata;
    assign reg_waddr_out    = r.reg_waddr;
    assign reg_we_out       = r.reg_we;
    assign csr_we_out       = r.csr_we;
    assign csr_wdata_out    = r.csr_wdata;
    assign csr_waddr_out    = r.csr_waddr;

`ifdef MEM_WB_RETIRE_CNT_EN
    retire_counter #(.WIDTH(RETIRE_CNT_WIDTH)) u_retire_counter (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .inc_in  (!flush_in && !wb_stall_in && !mem_stall_in && valid_in),
        .cnt_out (retire_cnt_out)
    );
`else
    logic [31:0] unused_cnt_width;
    assign unused_cnt_width = RETIRE_CNT_WIDTH;
`endif
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed and randomized checks of mem_wb against a priority-rule reference model.
module tb_mem_wb;
    localparam int CW = 4;

    logic        clk_in = 1'b0;
    logic        reset_in, valid_in, reg_we_in, csr_we_in, mem_stall_in, wb_stall_in, flush_in;
    logic [31:0] inst_address_in, reg_wdata_in, csr_wdata_in;
    logic [4:0]  reg_waddr_in;
    logic [11:0] csr_waddr_in;
    logic        valid_out, reg_we_out, csr_we_out;
    logic [31:0] inst_address_out, reg_wdata_out, csr_wdata_out;
    logic [4:0]  reg_waddr_out;
    logic [11:0] csr_waddr_out;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CW-1:0] retire_cnt_out;
`endif

    int checks = 0;
    int failures = 0;

    logic        e_valid, e_we, e_cwe;
    logic [31:0] e_addr, e_wdata, e_cwdata;
    logic [4:0]  e_waddr;
    logic [11:0] e_cwaddr;
    int          e_cnt;

    always #5 clk_in = ~clk_in;

    mem_wb #(.RETIRE_CNT_WIDTH(CW)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .valid_in(valid_in),
        .inst_address_in(inst_address_in), .reg_wdata_in(reg_wdata_in),
        .reg_waddr_in(reg_waddr_in), .reg_we_in(reg_we_in), .csr_we_in(csr_we_in),
        .csr_wdata_in(csr_wdata_in), .csr_waddr_in(csr_waddr_in),
        .mem_stall_in(mem_stall_in), .wb_stall_in(wb_stall_in), .flush_in(flush_in),
        .valid_out(valid_out), .inst_address_out(inst_address_out),
        .reg_wdata_out(reg_wdata_out), .reg_waddr_out(reg_waddr_out),
        .reg_we_out(reg_we_out), .csr_we_out(csr_we_out),
        .csr_wdata_out(csr_wdata_out), .csr_waddr_out(csr_waddr_out)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .retire_cnt_out(retire_cnt_out)
`endif
    );

    task automatic model_bubble();
        e_valid = 0; e_addr = 0; e_wdata = 0; e_waddr = 0;
        e_we = 0; e_cwe = 0; e_cwdata = 0; e_cwaddr = 0;
    endtask

    // Reference: apply the highest-priority action for the inputs present at this edge
    task automatic tick();
        if (!reset_in) begin
            model_bubble();
            e_cnt = 0;
        end else if (flush_in) model_bubble();
        else if (wb_stall_in) begin
        end else if (mem_stall_in) model_bubble();
        else begin
            e_valid = valid_in; e_addr = inst_address_in; e_wdata = reg_wdata_in;
            e_waddr = reg_waddr_in; e_cwdata = csr_wdata_in; e_cwaddr = csr_waddr_in;
            e_we = valid_in ? reg_we_in : 1'b0;
            e_cwe = valid_in ? csr_we_in : 1'b0;
            if (valid_in) e_cnt = (e_cnt + 1) % (1 << CW);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic randomize_data();
        inst_address_in = $urandom; reg_wdata_in = $urandom; csr_wdata_in = $urandom;
        reg_waddr_in = 5'($urandom); csr_waddr_in = 12'($urandom);
        reg_we_in = 1'($urandom); csr_we_in = 1'($urandom);
    endtask

    task automatic test_reset();
        reset_in = 0; valid_in = 1; reg_we_in = 1; reg_waddr_in = 5; csr_we_in = 1;
        repeat (2) tick();
        checks++;
        if ({valid_out, reg_we_out, csr_we_out, reg_waddr_out, csr_waddr_out} !== 20'd0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%0b we=%0b cwe=%0b wa=%0d ca=%0h want all zero",
                     valid_out, reg_we_out, csr_we_out, reg_waddr_out, csr_waddr_out);
        end
        checks++;
        if ({inst_address_out, reg_wdata_out, csr_wdata_out} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got pc=%h wd=%h cd=%h want zero",
                     inst_address_out, reg_wdata_out, csr_wdata_out);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        checks++;
        if (retire_cnt_out !== 0) begin
            failures++;
            $display("FAIL reset_cnt got %0d want 0", retire_cnt_out);
        end
`endif
    endtask

    task automatic test_load();
        reset_in = 1; valid_in = 1; reg_we_in = 1; reg_waddr_in = 7;
        reg_wdata_in = 32'hDEADBEEF; inst_address_in = 32'h80;
        csr_we_in = 0; csr_wdata_in = 32'h1234; csr_waddr_in = 12'h305;
        tick();
        checks++;
        if ({valid_out, reg_we_out, reg_waddr_out, reg_wdata_out, inst_address_out} !==
            {1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80}) begin
            failures++;
            $display("FAIL load got v=%0b we=%0b wa=%0d wd=%h pc=%h want 1 1 7 deadbeef 80",
                     valid_out, reg_we_out, reg_waddr_out, reg_wdata_out, inst_address_out);
        end
        checks++;
        if ({csr_we_out, csr_waddr_out, csr_wdata_out} !== {1'b0, 12'h305, 32'h1234}) begin
            failures++;
            $display("FAIL load_csr got we=%0b a=%h d=%h want 0 305 1234",
                     csr_we_out, csr_waddr_out, csr_wdata_out);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        checks++;
        if (retire_cnt_out !== 1) begin
            failures++;
            $display("FAIL load_cnt got %0d want 1", retire_cnt_out);
        end
`endif
    endtask

    task automatic test_hold();
        wb_stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            valid_in = 1; mem_stall_in = 1'($urandom);
            tick();
            checks++;
            if ({valid_out, reg_we_out, reg_waddr_out, reg_wdata_out, inst_address_out} !==
                {1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80}) begin
                failures++;
                $display("FAIL hold[%0d] got v=%0b we=%0b wa=%0d wd=%h pc=%h want 1 1 7 deadbeef 80",
                         i, valid_out, reg_we_out, reg_waddr_out, reg_wdata_out, inst_address_out);
            end
`ifdef MEM_WB_RETIRE_CNT_EN
            checks++;
            if (retire_cnt_out !== 1) begin
                failures++;
                $display("FAIL hold_cnt[%0d] got %0d want 1", i, retire_cnt_out);
            end
`endif
        end
        wb_stall_in = 0; mem_stall_in = 0;
    endtask

    task automatic test_bubble();
        mem_stall_in = 1; wb_stall_in = 0; valid_in = 1; reg_we_in = 1; reg_waddr_in = 9;
        tick();
        checks++;
        if ({reg_we_out, valid_out, reg_waddr_out} !== 7'd0) begin
            failures++;
            $display("FAIL bubble got we=%0b v=%0b wa=%0d want 0 0 0", reg_we_out, valid_out, reg_waddr_out);
        end
        mem_stall_in = 0;
    endtask

    task automatic test_flush();
        tick();
        flush_in = 1; wb_stall_in = 1; mem_stall_in = 1; valid_in = 1;
        csr_we_in = 1; csr_waddr_in = 12'h300;
        tick();
        checks++;
        if ({csr_we_out, csr_waddr_out, valid_out, reg_we_out} !== 15'd0) begin
            failures++;
            $display("FAIL flush got cwe=%0b ca=%h v=%0b we=%0b want 0 000 0 0",
                     csr_we_out, csr_waddr_out, valid_out, reg_we_out);
        end
        flush_in = 0; wb_stall_in = 0; mem_stall_in = 0;
    endtask

    task automatic test_reset_mid_stall();
        valid_in = 1; reg_we_in = 1;
        tick();
        reset_in = 0; wb_stall_in = 1;
        tick();
        checks++;
        if ({valid_out, reg_we_out, inst_address_out} !== 34'd0) begin
            failures++;
            $display("FAIL reset_stall got v=%0b we=%0b pc=%h want 0 0 0", valid_out, reg_we_out, inst_address_out);
        end
        reset_in = 1; wb_stall_in = 0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            randomize_data();
            valid_in = 1;
            tick();
`ifdef MEM_WB_RETIRE_CNT_EN
            checks++;
            if (retire_cnt_out !== CW'(i + 1)) begin
                failures++;
                $display("FAIL wrap[%0d] got %0d want %0d", i, retire_cnt_out, (i + 1) % 16);
            end
`endif
        end
        valid_in = 0; reg_we_in = 1; csr_we_in = 1;
        tick();
        checks++;
        if ({reg_we_out, csr_we_out, valid_out} !== 3'd0) begin
            failures++;
            $display("FAIL invalid_we got we=%0b cwe=%0b v=%0b want 0 0 0", reg_we_out, csr_we_out, valid_out);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        checks++;
        if (retire_cnt_out !== 0) begin
            failures++;
            $display("FAIL invalid_cnt got %0d want 0", retire_cnt_out);
        end
`endif
    endtask

    task automatic test_random();
        logic [115:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            randomize_data();
            valid_in = 1'($urandom);
            reset_in = $urandom_range(0, 29) != 0;
            flush_in = $urandom_range(0, 9) == 0;
            wb_stall_in = $urandom_range(0, 9) < 2;
            mem_stall_in = $urandom_range(0, 9) < 2;
            tick();
            got = {valid_out, inst_address_out, reg_wdata_out, reg_waddr_out, reg_we_out,
                   csr_we_out, csr_wdata_out, csr_waddr_out};
            exp = {e_valid, e_addr, e_wdata, e_waddr, e_we, e_cwe, e_cwdata, e_cwaddr};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random[%0d] got %h want %h", i, got, exp);
            end
`ifdef MEM_WB_RETIRE_CNT_EN
            checks++;
            if (retire_cnt_out !== CW'(e_cnt)) begin
                failures++;
                $display("FAIL random_cnt[%0d] got %0d want %0d", i, retire_cnt_out, e_cnt);
            end
`endif
        end
        reset_in = 1; flush_in = 0; wb_stall_in = 0; mem_stall_in = 0;
    endtask

    initial begin
        reset_in = 0; valid_in = 0; reg_we_in = 0; csr_we_in = 0;
        mem_stall_in = 0; wb_stall_in = 0; flush_in = 0;
        inst_address_in = 0; reg_wdata_in = 0; csr_wdata_in = 0;
        reg_waddr_in = 0; csr_waddr_in = 0; e_cnt = 0;
        model_bubble();
        test_reset();
        test_load();
        test_hold();
        test_bubble();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
